data_dist_4: RTL and testbench
==============================

Name: data_dist_4

Overview:
1-to-4 data distributor (demultiplexer): the inverse of the 4-input data selector. It accepts words on one valid/ready input stream and routes each word to one of four registered output channels. The channel comes from an explicit 2-bit select, or from an internal round-robin pointer. It sits between a single producer and four consumers that each apply independent backpressure.

Parameters:
DW, 8, data width of input and of each output channel
RR_EN, 0, 0 = route by in_sel; 1 = ignore in_sel, route by internal round-robin pointer

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  distributor can accept the word this cycle
in_data  input  DW  input word
in_sel  input  2  target channel (S1,S0 encoding: 0..3), sampled with in_data; unused when RR_EN=1
out_valid  output  4  per-channel valid, bit i = channel i
out_ready  input  4  per-channel consumer ready
out_data  output  4*DW  packed channel data, channel i at [i*DW +: DW]
rr_ptr  output  2  current round-robin target (always 0 when RR_EN=0)
busy  output  1  OR of out_valid

Behaviour:
- Reset (rst_n low, async): out_valid=0, all out_data=0, rr_ptr=0, busy=0. Takes effect immediately regardless of clk. Words held in channel registers are discarded; no handshake completes during reset.
- Target channel: tgt = in_sel when RR_EN=0, else rr_ptr.
- Each channel has a one-entry holding register (vld_q[i], dat_q[i]). out_valid[i]=vld_q[i]; out_data slice i = dat_q[i].
- in_ready = ~vld_q[tgt] | out_ready[tgt]. This is combinational from in_sel/rr_ptr, vld_q and out_ready; there is no combinational path from in_valid or in_data.
- Accept: in_valid & in_ready. On the next edge, dat_q[tgt] <= in_data and vld_q[tgt] <= 1. Latency from input handshake to out_valid is exactly 1 cycle.
- Pop: out_valid[i] & out_ready[i]. On the next edge, vld_q[i] <= 0, unless channel i is accepting a new word on the same edge; in that case vld_q stays 1 and dat_q takes the new word (back-to-back, full throughput on a single channel).
- A stalled channel blocks only words targeted at it. In select mode, a producer may change in_sel to reach a free channel; there is no ordering guarantee across channels.
- dat_q[i] holds its last value while vld_q[i]=0. It is updated only on accept.
- Round-robin (RR_EN=1): rr_ptr advances by 1 mod 4 on each accept (3 -> 0 wrap) and holds otherwise. It does not skip full channels; a full target stalls input until it drains.
- in_valid high with in_ready low: no state change. The producer must hold in_data/in_sel stable until accepted.
- busy = |vld_q, registered-derived, no glitches from inputs.
- Only rst_n clears state; there is no sync clear.

Test Plan:
1. Reset mid-traffic: fill channels 0 and 2, assert rst_n=0 between edges -> out_valid=0000 and out_data=0 immediately, before the next edge; rr_ptr=0.
2. Select routing: RR_EN=0, out_ready=1111, send 0xA0..0xA3 with in_sel=0..3 on consecutive cycles -> out_valid[i] pulses one cycle after each accept with out_data slice i = 0xA0+i; in_ready stays 1 throughout.
3. Backpressure: out_ready[1]=0, send 0x11 then 0x22 to sel=1 -> 0x11 held on channel 1 and in_ready=0 for the 0x22 attempt; send 0x33 to sel=3 -> accepted and appears on channel 3; raise out_ready[1] -> 0x11 pops, 0x22 accepted same cycle and appears the next cycle.
4. Single-channel throughput: out_ready[2]=1, 8 consecutive words 0x01..0x08 to sel=2 -> in_ready constant 1, out_valid[2] high 8 consecutive cycles with data in order.
5. Round-robin wrap: RR_EN=1, out_ready=1111, send 6 words 0x10..0x15 -> channels 0,1,2,3,0,1 in order; rr_ptr reads 2 after the sixth accept.
6. RR stall: RR_EN=1, out_ready[0]=0 with channel 0 full and rr_ptr=0 -> in_ready=0 and rr_ptr holds; release out_ready[0] -> accept resumes and rr_ptr advances to 1.

Source files
------------

// File: rtl/data_dist_4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_dist_4 : 1-to-4 valid/ready distributor with one-entry output slots   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module data_dist_4 #(
  parameter int DW    = 8,
  parameter int RR_EN = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [1:0]      in_sel,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [4*DW-1:0] out_data,
  output logic [1:0]      rr_ptr,
  output logic            busy
);

  logic [3:0]    r_vld;
  logic [DW-1:0] r_dat [4];
  logic [1:0]    r_ptr;

  logic [1:0] w_tgt;
  logic       w_accept;
  logic [3:0] w_load;
  logic [3:0] w_pop;

  assign w_tgt    = (RR_EN != 0) ? r_ptr : in_sel;
  // Ready depends only on the target slot, never on in_valid/in_data.
  assign in_ready = ~r_vld[w_tgt] | out_ready[w_tgt];
  assign w_accept = in_valid & in_ready;
  assign w_load   = w_accept ? (4'b0001 << w_tgt) : 4'b0000;
  assign w_pop    = r_vld & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_ptr <= '0;
      for (int i = 0; i < 4; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      // A load on the same edge as a pop keeps the slot full.
      r_vld <= w_load | (r_vld & ~w_pop);
      for (int i = 0; i < 4; i++) begin
        if (w_load[i]) begin
          r_dat[i] <= in_data;
        end
      end
      if ((RR_EN != 0) && w_accept) begin
        r_ptr <= r_ptr + 2'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      assign out_data[gi*DW +: DW] = r_dat[gi];
    end
  endgenerate

  assign out_valid = r_vld;
  assign rr_ptr    = r_ptr;
  assign busy      = |r_vld;

endmodule
`default_nettype wire

// File: tb/tb_data_dist_4.sv
`default_nettype none
// Bench for data_dist_4: one select-mode and one round-robin instance, a
// directed vector table, hand sequences and random traffic against a model.
module tb_data_dist_4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;

  logic       iv   [2];
  logic [1:0] isel [2];
  logic [7:0] id   [2];
  logic [3:0] ordy [2];

  wire        ir [2];
  wire [3:0]  ov [2];
  wire [31:0] od [2];
  wire [1:0]  rp [2];
  wire        bz [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_dist_4 #(.DW(8), .RR_EN(0)) u_sel (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_sel(isel[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .rr_ptr(rp[0]), .busy(bz[0])
  );

  data_dist_4 #(.DW(8), .RR_EN(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_sel(isel[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .rr_ptr(rp[1]), .busy(bz[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each channel is a slot that is either empty or holds a
  // word; the round-robin target is simply the number of accepts modulo 4.
  bit          mv  [2][4];
  logic [7:0]  md  [2][4];
  int unsigned acc [2];

  function automatic logic [1:0] mtgt(int m);
    return (m == 1) ? 2'(acc[1] % 4) : isel[m];
  endfunction

  function automatic bit mrdy(int m);
    logic [1:0] t;
    t = mtgt(m);
    return !mv[m][t] || ordy[m][t];
  endfunction

  logic [1:0] m_t;
  bit         m_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        acc[m] = 0;
        for (int i = 0; i < 4; i++) begin
          mv[m][i] = 1'b0;
          md[m][i] = 8'h00;
        end
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        m_t = mtgt(m);
        m_r = mrdy(m);
        for (int i = 0; i < 4; i++) begin
          if (mv[m][i] && ordy[m][i]) mv[m][i] = 1'b0;
        end
        if (iv[m] && m_r) begin
          mv[m][m_t] = 1'b1;
          md[m][m_t] = id[m];
          acc[m]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d_in_ready", m), {31'd0, ir[m]}, {31'd0, mrdy(m)});
        chk($sformatf("m%0d_out_valid", m), {28'd0, ov[m]},
            {28'd0, mv[m][3], mv[m][2], mv[m][1], mv[m][0]});
        chk($sformatf("m%0d_out_data", m), od[m], {md[m][3], md[m][2], md[m][1], md[m][0]});
        chk($sformatf("m%0d_rr_ptr", m), {30'd0, rp[m]}, (m == 1) ? (acc[1] % 4) : 32'd0);
        chk($sformatf("m%0d_busy", m), {31'd0, bz[m]},
            {31'd0, mv[m][0] | mv[m][1] | mv[m][2] | mv[m][3]});
      end
    end
  end

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [7:0]  d;
    logic [3:0]  ordy;
    logic        rdy;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
  } vec_t;

  vec_t tv [17];
  bit   hold [2];

  initial begin
    // Select routing, backpressure on channel 1, then single-channel streaming.
    tv[0] = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b1, 4'b0001, 32'h000000A0};
    tv[1] = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0};
    tv[2] = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0};
    tv[3] = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0};
    tv[4] = '{1'b1, 2'd1, 8'h11, 4'hD, 1'b1, 4'b0010, 32'hA3A211A0};
    tv[5] = '{1'b1, 2'd1, 8'h22, 4'hD, 1'b0, 4'b0010, 32'hA3A211A0};
    tv[6] = '{1'b1, 2'd3, 8'h33, 4'hD, 1'b1, 4'b1010, 32'h33A211A0};
    tv[7] = '{1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'b0010, 32'h33A222A0};
    for (int j = 0; j < 8; j++) begin
      tv[8+j] = '{1'b1, 2'd2, 8'(j + 1), 4'hF, 1'b1, 4'b0100,
                  {8'h33, 8'(j + 1), 8'h22, 8'hA0}};
    end
    tv[16] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h330822A0};

    for (int m = 0; m < 2; m++) begin
      iv[m] = 1'b0; isel[m] = 2'd0; id[m] = 8'h00; ordy[m] = 4'h0; hold[m] = 1'b0;
    end

    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_out_valid", {28'd0, ov[m]}, 32'd0);
      chk("rst_out_data", od[m], 32'd0);
      chk("rst_rr_ptr", {30'd0, rp[m]}, 32'd0);
      chk("rst_busy", {31'd0, bz[m]}, 32'd0);
    end
    tick();

    // Fill two slots in each instance, then reset between edges.
    for (int m = 0; m < 2; m++) begin
      iv[m] = 1'b1; isel[m] = 2'd0; id[m] = 8'h5A; ordy[m] = 4'h0;
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      isel[m] = 2'd2; id[m] = 8'hC3;
    end
    tick();
    for (int m = 0; m < 2; m++) iv[m] = 1'b0;
    chk("fill_sel_ov", {28'd0, ov[0]}, 32'h5);
    chk("fill_sel_od", od[0], 32'h00C3005A);
    chk("fill_rr_od", od[1], 32'h0000C35A);
    chk("fill_rr_ptr", {30'd0, rp[1]}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("async_rst_ov", {28'd0, ov[m]}, 32'd0);
      chk("async_rst_od", od[m], 32'd0);
      chk("async_rst_ptr", {30'd0, rp[m]}, 32'd0);
      chk("async_rst_busy", {31'd0, bz[m]}, 32'd0);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();

    ordy[1] = 4'hF;
    for (int k = 0; k < 17; k++) begin
      iv[0] = tv[k].v; isel[0] = tv[k].sel; id[0] = tv[k].d; ordy[0] = tv[k].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy", k), {31'd0, ir[0]}, {31'd0, tv[k].rdy});
      tick();
      chk($sformatf("tbl%0d_ov", k), {28'd0, ov[0]}, {28'd0, tv[k].exp_ov});
      chk($sformatf("tbl%0d_od", k), od[0], tv[k].exp_od);
    end
    iv[0] = 1'b0;

    // Round-robin wrap over six words.
    for (int k = 0; k < 6; k++) begin
      iv[1] = 1'b1; id[1] = 8'(8'h10 + k); ordy[1] = 4'hF;
      @(negedge clk);
      chk("rr_rdy", {31'd0, ir[1]}, 32'd1);
      chk("rr_ptr_pre", {30'd0, rp[1]}, 32'(k % 4));
      tick();
      chk("rr_ov", {28'd0, ov[1]}, 32'(1 << (k % 4)));
      chk("rr_od", {24'd0, od[1][(k%4)*8 +: 8]}, 32'(8'h10 + k));
    end
    iv[1] = 1'b0;
    chk("rr_ptr_wrap", {30'd0, rp[1]}, 32'd2);

    // Park a word in channel 0 and come back around to it.
    for (int k = 0; k < 6; k++) begin
      iv[1] = 1'b1; id[1] = 8'(8'h16 + k); ordy[1] = 4'hE;
      @(negedge clk);
      chk("rrfill_rdy", {31'd0, ir[1]}, 32'd1);
      tick();
    end
    id[1] = 8'h1C;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_rdy", {31'd0, ir[1]}, 32'd0);
      chk("stall_ptr", {30'd0, rp[1]}, 32'd0);
      tick();
      chk("stall_hold_ov", {28'd0, ov[1]}, 32'h1);
      chk("stall_hold_od", {24'd0, od[1][7:0]}, 32'h18);
    end
    ordy[1] = 4'hF;
    @(negedge clk);
    chk("release_rdy", {31'd0, ir[1]}, 32'd1);
    tick();
    iv[1] = 1'b0;
    chk("release_ptr", {30'd0, rp[1]}, 32'd1);
    chk("release_ov", {28'd0, ov[1]}, 32'h1);
    chk("release_od", {24'd0, od[1][7:0]}, 32'h1C);

    // Random traffic; producer holds a stalled word until it is taken.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      for (int m = 0; m < 2; m++) begin
        if (!hold[m]) begin
          iv[m]   = ($urandom % 4) != 0;
          isel[m] = 2'($urandom);
          id[m]   = 8'($urandom);
        end
        ordy[m] = 4'($urandom);
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) hold[m] = iv[m] && !ir[m] && rst_n;
      tick();
    end

    for (int m = 0; m < 2; m++) iv[m] = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
